alu_seq_exec: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shift_add_mul.sv | 76 +++++++
 rtl/alu_seq_exec.sv | 174 +++++++++++++++++
 tb/tb_alu_seq_exec.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, status bit indices and FSM state type shared by the
//               sequential execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_MLA = 4'b1011;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_add_mul
// Description : Iterative shift-add multiplier with accumulator preload;
//               WIDTH iterations, product is the low WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] addend,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = addend;
            mcand_d  = multiplicand;
            mplier_d = multiplier;
            count_d  = CW'(WIDTH);
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - 1'b1;
            if (count_q == CW'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    // The final iteration's sum is presented directly so the top can
    // capture it on the same edge that ends the run.
    assign done    = run_q && (count_q == CW'(1));
    assign product = acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            run_q    <= run_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_exec
// Description : Registered execute-stage ALU with NZCV status register and
//               valid/ready handshake. Define ALU_MUL_EN to build MUL/MLA.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cmd,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] val3,
    input  logic             shifter_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       status_q, status_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             arith;
    logic [WIDTH-1:0] res;
    logic             flag_c;
    logic             flag_v;
    logic             upd;
    logic             is_mul;
    logic             accept;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic             mul_s_q, mul_s_d;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (accept && is_mul),
        .multiplicand (val1),
        .multiplier   (val2),
        .addend       ((cmd == CMD_MLA) ? val3 : '0),
        .done         (mul_done),
        .product      (mul_product)
    );

    assign mul_s_d = (accept && is_mul) ? s_bit : mul_s_q;
    assign busy    = (state_q == MULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_s_q <= 1'b0;
        end else begin
            mul_s_q <= mul_s_d;
        end
    end
`else
    logic unused_val3;
    assign unused_val3 = ^val3;
    assign busy        = 1'b0;
`endif

    always_comb begin
        op_b   = '0;
        cin    = 1'b0;
        arith  = 1'b0;
        res    = '0;
        flag_c = status_q[ST_C];
        flag_v = status_q[ST_V];
        upd    = 1'b0;
        is_mul = 1'b0;

        case (cmd)
            CMD_ADD: begin op_b = val2;  cin = 1'b0;           arith = 1'b1; end
            CMD_ADC: begin op_b = val2;  cin = status_q[ST_C]; arith = 1'b1; end
            CMD_SUB: begin op_b = ~val2; cin = 1'b1;           arith = 1'b1; end
            CMD_SBC: begin op_b = ~val2; cin = status_q[ST_C]; arith = 1'b1; end
            CMD_MOV: begin res = val2;         flag_c = shifter_carry; upd = 1'b1; end
            CMD_MVN: begin res = ~val2;        flag_c = shifter_carry; upd = 1'b1; end
            CMD_AND: begin res = val1 & val2;  flag_c = shifter_carry; upd = 1'b1; end
            CMD_ORR: begin res = val1 | val2;  flag_c = shifter_carry; upd = 1'b1; end
            CMD_EOR: begin res = val1 ^ val2;  flag_c = shifter_carry; upd = 1'b1; end
`ifdef ALU_MUL_EN
            CMD_MUL, CMD_MLA: is_mul = 1'b1;
`endif
            default: ;
        endcase

        // Subtract runs as val1 + ~val2 + cin, so C is the no-borrow flag.
        sum = {1'b0, val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            res    = sum[WIDTH-1:0];
            flag_c = sum[WIDTH];
            flag_v = (val1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
            upd    = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        status_d    = status_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (is_mul) begin
                state_d = MULT;
            end else begin
                result_d    = res;
                out_valid_d = 1'b1;
                if (s_bit && upd) begin
                    status_d[ST_N] = res[WIDTH-1];
                    status_d[ST_Z] = (res == '0);
                    status_d[ST_C] = flag_c;
                    status_d[ST_V] = flag_v;
                end
            end
        end
`ifdef ALU_MUL_EN
        if ((state_q == MULT) && mul_done) begin
            result_d    = mul_product;
            out_valid_d = 1'b1;
            state_d     = IDLE;
            if (mul_s_q) begin
                status_d[ST_N] = mul_product[WIDTH-1];
                status_d[ST_Z] = (mul_product == '0);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            status_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            status_q    <= status_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_exec
// Description : Directed self-checking bench for alu_seq_exec (WIDTH=32);
//               MUL/MLA vectors are selected by ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_exec;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       cmd = 4'b0000;
    logic             s_bit = 1'b0;
    logic [WIDTH-1:0] val1 = '0;
    logic [WIDTH-1:0] val2 = '0;
    logic [WIDTH-1:0] val3 = '0;
    logic             shifter_carry = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic [3:0]       status;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_exec #(
        .WIDTH(WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cmd           (cmd),
        .s_bit         (s_bit),
        .val1          (val1),
        .val2          (val2),
        .val3          (val3),
        .shifter_carry (shifter_carry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .status        (status),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input logic sc);
        in_valid      = 1'b1;
        cmd           = c;
        s_bit         = s;
        val1          = a;
        val2          = b;
        val3          = d;
        shifter_carry = sc;
    endtask

    task automatic issue(input logic [3:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input logic sc);
        drive(c, s, a, b, d, sc);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        cyc();
        cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_status", {60'd0, status}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD overflow: N=1 Z=0 C=0 V=1
        issue(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0);
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_result", {32'd0, result}, 64'h8000_0000);
        chk("add_status", {60'd0, status}, 64'b1001);

        // SUB 5-5: Z=1 C=1
        issue(4'b0100, 1'b1, 32'd5, 32'd5, 32'h0, 1'b0);
        chk("sub_result", {32'd0, result}, 64'd0);
        chk("sub_status", {60'd0, status}, 64'b0110);

        // SBC 0x10-0x3 with C=1 -> 0xD, C=1
        issue(4'b0101, 1'b1, 32'h10, 32'h3, 32'h0, 1'b0);
        chk("sbc_result", {32'd0, result}, 64'h0000_000D);
        chk("sbc_status", {60'd0, status}, 64'b0010);

        // Set V again, then MOV 0 with shifter_carry=1 keeps V
        issue(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0);
        chk("add2_status", {60'd0, status}, 64'b1001);
        issue(4'b0001, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("mov_result", {32'd0, result}, 64'd0);
        chk("mov_status", {60'd0, status}, 64'b0111);

        // ORR without s_bit leaves status
        issue(4'b0111, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0, 1'b0);
        chk("orr_result", {32'd0, result}, 64'h0000_00FF);
        chk("orr_status", {60'd0, status}, 64'b0111);

        issue(4'b0110, 1'b1, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'h0, 1'b0);
        chk("and_result", {32'd0, result}, 64'hF000_F000);
        chk("and_status", {60'd0, status}, 64'b1001);

        issue(4'b1001, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("mvn_result", {32'd0, result}, 64'hFFFF_FFFF);
        chk("mvn_status", {60'd0, status}, 64'b1011);

        // ADC uses registered C=1: 0xFFFFFFFF + 0 + 1
        issue(4'b0011, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        chk("adc_result", {32'd0, result}, 64'd0);
        chk("adc_status", {60'd0, status}, 64'b0110);

        // Unused opcodes: result 0, status unchanged
        issue(4'b0000, 1'b1, 32'h1234_5678, 32'h1, 32'h0, 1'b0);
        chk("nop0_result", {32'd0, result}, 64'd0);
        chk("nop0_status", {60'd0, status}, 64'b0110);
        issue(4'b1111, 1'b1, 32'h8000_0000, 32'h1, 32'h0, 1'b1);
        chk("nopf_valid", {63'd0, out_valid}, 64'd1);
        chk("nopf_status", {60'd0, status}, 64'b0110);

        // Back-to-back throughput
        drive(4'b0010, 1'b0, 32'd1, 32'd2, 32'h0, 1'b0);
        cyc();
        chk("b2b_first", {32'd0, result}, 64'd3);
        drive(4'b0010, 1'b0, 32'd10, 32'd20, 32'h0, 1'b0);
        cyc();
        chk("b2b_second", {32'd0, result}, 64'd30);
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: stray EOR presented while stalled must be ignored
        out_ready = 1'b0;
        issue(4'b0010, 1'b0, 32'd2, 32'd3, 32'h0, 1'b0);
        drive(4'b1000, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 1'b0);
        #1;
        chk("bp_in_ready0", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_result", {32'd0, result}, 64'd5);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_status", {60'd0, status}, 64'b0110);
        end
        out_ready = 1'b1;
        drive(4'b1000, 1'b0, 32'h0000_00FF, 32'h0000_000F, 32'h0, 1'b0);
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("eor_result", {32'd0, result}, 64'h0000_00F0);
        chk("eor_valid", {63'd0, out_valid}, 64'd1);
        cyc();
        chk("eor_retired", {63'd0, out_valid}, 64'd0);

`ifdef ALU_MUL_EN
        // MLA 7*6+3 over WIDTH cycles
        issue(4'b1011, 1'b1, 32'd7, 32'd6, 32'd3, 1'b0);
        chk("mla_busy", {63'd0, busy}, 64'd1);
        chk("mla_in_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 1; i < WIDTH; i++) begin
            cyc();
            chk("mla_wait_valid", {63'd0, out_valid}, 64'd0);
            chk("mla_wait_busy", {63'd0, busy}, 64'd1);
        end
        cyc();
        chk("mla_valid", {63'd0, out_valid}, 64'd1);
        chk("mla_result", {32'd0, result}, 64'd45);
        chk("mla_busy_end", {63'd0, busy}, 64'd0);
        chk("mla_status", {60'd0, status}, 64'b0010);

        issue(4'b1010, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd99, 1'b0);
        repeat (WIDTH) cyc();
        chk("mul_result", {32'd0, result}, 64'hFFFF_FFFE);
        chk("mul_status", {60'd0, status}, 64'b1010);
        cyc();

        // Reset at the 10th MULT cycle aborts with no result
        issue(4'b1010, 1'b1, 32'd3, 32'd3, 32'd0, 1'b0);
        repeat (9) cyc();
        chk("abort_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
`else
        // Without the multiplier, 1010/1011 are unused opcodes
        issue(4'b1011, 1'b1, 32'd7, 32'd6, 32'd3, 1'b0);
        chk("mla_off_valid", {63'd0, out_valid}, 64'd1);
        chk("mla_off_result", {32'd0, result}, 64'd0);
        chk("mla_off_busy", {63'd0, busy}, 64'd0);
        chk("mla_off_status", {60'd0, status}, 64'b0110);

        // Reset while a result is held under backpressure
        out_ready = 1'b0;
        issue(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
`endif
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_status", {60'd0, status}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        chk("abort_no_stale", {63'd0, out_valid}, 64'd0);

        issue(4'b0010, 1'b1, 32'd1, 32'd1, 32'd0, 1'b0);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_result", {32'd0, result}, 64'd2);
        chk("post_rst_status", {60'd0, status}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
